// File: rtl/retry_buf_wr_sched_pkg.sv
// retry_pkg: shared constants and types for the retry-buffer write scheduler.
//   FLIT_W / BUFF_DEPTH / PTR_W : default flit width, buffer depth, pointer width
//   wr_sched_state_e            : scheduler FSM states (RUN, REPLAY)
//   grant_src_e                 : arbitration source (PROT, LLC)
package retry_pkg;

  localparam int FLIT_W     = 528;
  localparam int BUFF_DEPTH = 64;
  localparam int PTR_W      = 6;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_REPLAY = 1'b1;

  typedef enum logic [0:0] {
    RUN    = ST_RUN,
    REPLAY = ST_REPLAY
  } wr_sched_state_e;

  typedef enum logic [0:0] {
    PROT = 1'b0,
    LLC  = 1'b1
  } grant_src_e;

endpackage

// File: rtl/retry_buf_wr_sched_if.sv
// retry_buf_wr_sched_if: flit handshakes, free-count/replay/flush status and
// the retry-buffer write port of the write scheduler.
//   master : flit sources and status producers (drives i_*, observes o_*)
//   slave  : the scheduler (observes i_*, drives o_*)
interface retry_buf_wr_sched_if #(
  parameter int FLIT_W = retry_pkg::FLIT_W,
  parameter int PTR_W  = retry_pkg::PTR_W
);

  logic              i_prot_valid;
  logic              o_prot_ready;
  logic [FLIT_W-1:0] i_prot_flit;
  logic              i_llc_valid;
  logic              o_llc_ready;
  logic [FLIT_W-1:0] i_llc_flit;
  logic [7:0]        i_retry_num_free_buff;
  logic              i_replay_active;
  logic              i_flush;
  logic              o_wr_en;
  logic [PTR_W-1:0]  o_wr_addr;
  logic [FLIT_W-1:0] o_wr_data;
  logic              o_wr_is_llc;

  modport master (
    output i_prot_valid, i_prot_flit, i_llc_valid, i_llc_flit,
           i_retry_num_free_buff, i_replay_active, i_flush,
    input  o_prot_ready, o_llc_ready, o_wr_en, o_wr_addr, o_wr_data, o_wr_is_llc
  );

  modport slave (
    input  i_prot_valid, i_prot_flit, i_llc_valid, i_llc_flit,
           i_retry_num_free_buff, i_replay_active, i_flush,
    output o_prot_ready, o_llc_ready, o_wr_en, o_wr_addr, o_wr_data, o_wr_is_llc
  );

endinterface

// File: rtl/retry_buf_wr_sched_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clr        : synchronous clear of the last-grant register
//   i_en         : allows the last-grant register to update on a grant
//   i_req[0]=PROT, i_req[1]=LLC ; o_gnt one-hot (or zero), combinational
module rr_arb2
  import retry_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  grant_src_e r_last;

  always_comb begin
    o_gnt = '0;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      // Tie goes to whichever side did not win last time.
      2'b11:   o_gnt = (r_last == LLC) ? 2'b01 : 2'b10;
      default: o_gnt = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= LLC;
    end else if (i_clr) begin
      r_last <= LLC;
    end else if (i_en && (o_gnt != 2'b00)) begin
      r_last <= o_gnt[1] ? LLC : PROT;
    end
  end

endmodule

// File: rtl/retry_buf_wr_sched.sv
// retry_buf_wr_sched: retry-buffer write scheduler. Arbitrates protocol and
// LLCTRL flits, gates on the free-entry count, blocks during replay and
// issues one registered write per granted flit (wr_en doubles as the
// free-counter decrement).
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus (slave)  : flit handshakes, free count, replay, flush, write port
module retry_buf_wr_sched #(
  parameter int FLIT_W      = retry_pkg::FLIT_W,
  parameter int BUFF_DEPTH  = retry_pkg::BUFF_DEPTH,
  parameter int PTR_W       = retry_pkg::PTR_W,
  parameter int LLC_RESERVE = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  retry_buf_wr_sched_if.slave   bus
);

  import retry_pkg::*;

  wr_sched_state_e   r_state;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic              r_wr_en;
  logic [PTR_W-1:0]  r_wr_addr;
  logic [FLIT_W-1:0] r_wr_data;
  logic              r_wr_is_llc;

  logic [8:0] w_eff_free;
  logic       w_run;
  logic [1:0] w_req;
  logic [1:0] w_gnt;

  // The write issued last cycle is not yet reflected in the counter value.
  always_comb begin
    w_eff_free = '0;
    if (bus.i_retry_num_free_buff != 8'd0) begin
      w_eff_free = {1'b0, bus.i_retry_num_free_buff} - {8'd0, r_wr_en};
    end
  end

  assign w_run = !i_rst && !bus.i_flush && !bus.i_replay_active && (r_state == RUN);

  always_comb begin
    w_req    = '0;
    w_req[0] = w_run && bus.i_prot_valid && (w_eff_free > 9'(LLC_RESERVE));
    w_req[1] = w_run && bus.i_llc_valid  && (w_eff_free != 9'd0);
  end

  rr_arb2 u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (bus.i_flush),
    .i_en  (w_run),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign bus.o_prot_ready = w_gnt[0];
  assign bus.o_llc_ready  = w_gnt[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= RUN;
    end else if (bus.i_flush) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:     if (bus.i_replay_active)  r_state <= REPLAY;
        REPLAY:  if (!bus.i_replay_active) r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_is_llc <= 1'b0;
    end else if (bus.i_flush) begin
      r_wr_ptr <= '0;
      r_wr_en  <= 1'b0;
    end else if (w_gnt != 2'b00) begin
      r_wr_en     <= 1'b1;
      r_wr_addr   <= r_wr_ptr;
      r_wr_data   <= w_gnt[1] ? bus.i_llc_flit : bus.i_prot_flit;
      r_wr_is_llc <= w_gnt[1];
      r_wr_ptr    <= (r_wr_ptr == PTR_W'(BUFF_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    end else begin
      r_wr_en <= 1'b0;
    end
  end

  assign bus.o_wr_en     = r_wr_en;
  assign bus.o_wr_addr   = r_wr_addr;
  assign bus.o_wr_data   = r_wr_data;
  assign bus.o_wr_is_llc = r_wr_is_llc;

endmodule

// File: tb/tb_retry_buf_wr_sched.sv
// tb_retry_buf_wr_sched: directed self-checking bench for retry_buf_wr_sched.
module tb_retry_buf_wr_sched;

  import retry_pkg::*;

  localparam int FW = FLIT_W;
  localparam int PW = PTR_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  retry_buf_wr_sched_if #(.FLIT_W(FW), .PTR_W(PW)) bus ();

  retry_buf_wr_sched #(
    .FLIT_W      (FW),
    .BUFF_DEPTH  (BUFF_DEPTH),
    .PTR_W       (PW),
    .LLC_RESERVE (1)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chkb(input string tag, input logic obs, input logic expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
    end
  endtask

  task automatic chka(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chkw(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rdy(input string tag, input logic p, input logic l);
    chkb({tag, "_prot_rdy"}, bus.o_prot_ready, p);
    chkb({tag, "_llc_rdy"},  bus.o_llc_ready,  l);
  endtask

  task automatic chk_wr(input string tag, input logic en, input int addr, input logic is_llc);
    chkb({tag, "_wr_en"},  bus.o_wr_en,     en);
    chka({tag, "_addr"},   bus.o_wr_addr,   PW'(addr));
    chkb({tag, "_is_llc"}, bus.o_wr_is_llc, is_llc);
  endtask

  initial begin
    logic exp_llc;
    rst                       = 1'b1;
    bus.i_prot_valid          = 1'b1;
    bus.i_llc_valid           = 1'b0;
    bus.i_prot_flit           = '0;
    bus.i_llc_flit            = '0;
    bus.i_retry_num_free_buff = 8'd64;
    bus.i_replay_active       = 1'b0;
    bus.i_flush               = 1'b0;

    // Reset values; readies stay low while reset is held even with a valid.
    repeat (2) @(posedge clk);
    #1;
    chk_wr("rst", 1'b0, 0, 1'b0);
    chkw("rst_data", bus.o_wr_data, '0);
    chk_rdy("rst", 1'b0, 1'b0);
    rst = 1'b0;

    // Streaming protocol flits: address 0..63 then wraps to 0,1.
    for (int k = 0; k < 66; k++) begin
      bus.i_prot_flit = FW'(k + 1);
      #1;
      chk_rdy("stream", 1'b1, 1'b0);
      cyc();
      chk_wr("stream", 1'b1, k % 64, 1'b0);
      chkw("stream_data", bus.o_wr_data, FW'(k + 1));
    end
    bus.i_prot_valid = 1'b0;
    #1;
    chk_rdy("idle", 1'b0, 1'b0);
    cyc();
    chk_wr("idle_hold", 1'b0, 1, 1'b0);
    chkw("idle_hold_data", bus.o_wr_data, FW'(66));

    // Both valid: last winner was PROT so LLC starts, then alternation.
    bus.i_prot_flit  = FW'(32'hA5A5);
    bus.i_llc_flit   = FW'(32'h5A5A);
    bus.i_prot_valid = 1'b1;
    bus.i_llc_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_llc = (i % 2 == 0);
      #1;
      chk_rdy("alt", !exp_llc, exp_llc);
      cyc();
      chk_wr("alt", 1'b1, 2 + i, exp_llc);
      chkw("alt_data", bus.o_wr_data, exp_llc ? FW'(32'h5A5A) : FW'(32'hA5A5));
    end
    bus.i_prot_valid = 1'b0;
    bus.i_llc_valid  = 1'b0;
    #1;
    cyc();
    chkb("alt_idle_wr_en", bus.o_wr_en, 1'b0);

    // Reserve gating with free=2 then free=1 while a write is in flight.
    bus.i_retry_num_free_buff = 8'd2;
    bus.i_prot_valid          = 1'b1;
    bus.i_llc_valid           = 1'b1;
    #1;
    chk_rdy("res0", 1'b1, 1'b0);
    cyc();
    chk_wr("res0", 1'b1, 7, 1'b0);
    #1;
    chk_rdy("res1", 1'b0, 1'b1);
    cyc();
    chk_wr("res1", 1'b1, 8, 1'b1);
    bus.i_retry_num_free_buff = 8'd1;
    #1;
    chk_rdy("res2", 1'b0, 1'b0);
    cyc();
    chk_wr("res2", 1'b0, 8, 1'b1);

    // Replay held for 5 cycles, then one more blocked cycle in REPLAY.
    bus.i_retry_num_free_buff = 8'd64;
    bus.i_replay_active       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_rdy("replay", 1'b0, 1'b0);
      cyc();
      chkb("replay_wr_en", bus.o_wr_en, 1'b0);
    end
    bus.i_replay_active = 1'b0;
    #1;
    chk_rdy("replay_fall", 1'b0, 1'b0);
    cyc();
    chkb("replay_fall_wr_en", bus.o_wr_en, 1'b0);
    #1;
    chk_rdy("resume", 1'b1, 1'b0);
    cyc();
    chk_wr("resume", 1'b1, 9, 1'b0);

    // Advance the pointer to 17, leaving PROT as the last winner.
    for (int i = 10; i < 17; i++) begin
      bus.i_prot_valid = (i == 16);
      bus.i_llc_valid  = (i != 16);
      #1;
      chk_rdy("adv", i == 16, i != 16);
      cyc();
      chk_wr("adv", 1'b1, i, i != 16);
    end

    // Flush: pointer back to 0 and arbiter favours PROT on the next tie.
    bus.i_prot_valid = 1'b1;
    bus.i_llc_valid  = 1'b1;
    bus.i_flush      = 1'b1;
    #1;
    chk_rdy("flush", 1'b0, 1'b0);
    cyc();
    chkb("flush_wr_en", bus.o_wr_en, 1'b0);
    bus.i_flush = 1'b0;
    #1;
    chk_rdy("post_flush0", 1'b1, 1'b0);
    cyc();
    chk_wr("post_flush0", 1'b1, 0, 1'b0);
    #1;
    chk_rdy("post_flush1", 1'b0, 1'b1);
    cyc();
    chk_wr("post_flush1", 1'b1, 1, 1'b1);

    // free=0 with a write in flight must floor at zero, not wrap.
    bus.i_retry_num_free_buff = 8'd0;
    #1;
    chk_rdy("floor", 1'b0, 1'b0);
    cyc();
    chkb("floor_wr_en", bus.o_wr_en, 1'b0);

    // free=1, nothing in flight: only LLCTRL may use the reserved entry.
    bus.i_retry_num_free_buff = 8'd1;
    #1;
    chk_rdy("reserve1", 1'b0, 1'b1);
    cyc();
    chk_wr("reserve1", 1'b1, 2, 1'b1);

    // Asynchronous reset mid-write.
    bus.i_retry_num_free_buff = 8'd64;
    bus.i_llc_valid           = 1'b0;
    bus.i_prot_flit           = FW'(32'hBEEF);
    #1;
    chk_rdy("pre_rst", 1'b1, 1'b0);
    cyc();
    chk_wr("pre_rst", 1'b1, 3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_wr("async_rst", 1'b0, 0, 1'b0);
    chkw("async_rst_data", bus.o_wr_data, '0);
    chk_rdy("async_rst", 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    #1;
    chk_rdy("post_rst", 1'b1, 1'b0);
    cyc();
    chk_wr("post_rst", 1'b1, 0, 1'b0);
    chkw("post_rst_data", bus.o_wr_data, FW'(32'hBEEF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/retry_buf_wr_sched.md
# retry_buf_wr_sched

Write scheduler for the link-layer retry buffer. It arbitrates between the protocol-flit TX path and the LLCTRL-flit TX path and sequences one retry-buffer write per cycle. It gates grants on the retry free-buffer count and blocks writes during replay. Its `o_wr_en` is the `controller_wr_en` that decrements the free-buffer counter, and it owns the retry-buffer write pointer (ESeq).

## Interface
- `FLIT_W`, default 528: flit width in bits.
- `BUFF_DEPTH`, default 64: retry buffer entries; power of 2.
- `PTR_W`, default 6: log2(`BUFF_DEPTH`).
- `LLC_RESERVE`, default 1: entries kept free for LLCTRL flits only.
- `i_clk`  in  1  clock; all logic is rising-edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_prot_valid`  in  1  protocol flit offered.
- `o_prot_ready`  out  1  protocol flit accepted this cycle (valid & ready).
- `i_prot_flit`  in  `FLIT_W`  protocol flit data.
- `i_llc_valid`  in  1  retryable LLCTRL flit offered.
- `o_llc_ready`  out  1  LLCTRL flit accepted this cycle.
- `i_llc_flit`  in  `FLIT_W`  LLCTRL flit data.
- `i_retry_num_free_buff`  in  8  current free-entry count from the free-buffer counter.
- `i_replay_active`  in  1  retry replay in progress; no new writes allowed.
- `i_flush`  in  1  link reinit; synchronous clear of the pointer and arbiter.
- `o_wr_en`  out  1  retry-buffer write strobe, also the free-count decrement.
- `o_wr_addr`  out  `PTR_W`  write address (ESeq).
- `o_wr_data`  out  `FLIT_W`  flit written.
- `o_wr_is_llc`  out  1  the written flit came from the LLCTRL path.

## Operation
- States: RUN, REPLAY. Reset state is RUN.
  - RUN→REPLAY when `i_replay_active`=1.
  - REPLAY→RUN on the first cycle `i_replay_active`=0.
  - Both readies are 0 in REPLAY and in the cycle `i_replay_active` is 1.
- Effective free count: eff_free = `i_retry_num_free_buff` − `o_wr_en`, computed at 9 bits and floored at 0. This covers the one write already issued but not yet seen by the counter.
- Eligibility in RUN:
  - prot_ok = `i_prot_valid` & (eff_free > `LLC_RESERVE`).
  - llc_ok = `i_llc_valid` & (eff_free ≥ 1).
- Arbitration: 2-way round-robin.
  - If only one requester is ok, it wins.
  - If both are ok, the one not granted last wins.
  - last_grant updates only on an actual grant. Its reset value is LLC, so protocol wins the first tie.
- Readies are combinational from state, eff_free, the valids and last_grant. At most one ready is high per cycle. A ready is never high without its valid.
- On a grant, the following register on the next edge: `o_wr_en`=1, `o_wr_data` = granted flit, `o_wr_is_llc`, `o_wr_addr` = wr_ptr. wr_ptr then increments modulo `BUFF_DEPTH` (63→0).
- With no grant, `o_wr_en`=0. `o_wr_data`, `o_wr_addr` and `o_wr_is_llc` hold their values.
- `i_flush` has priority over everything:
  - wr_ptr=0, last_grant=LLC, state=RUN.
  - `o_wr_en`=0 next cycle; both readies are 0 in the flush cycle.
- Simultaneous free-count increase (ack) and write are resolved by the counter; this block only consumes the count.
- Reset values: `o_wr_en`=0, `o_wr_addr`=0, `o_wr_data`=0, `o_wr_is_llc`=0, wr_ptr=0, state=RUN, last_grant=LLC. The readies are 0 during reset.
- Reset mid-operation: `o_wr_en` drops asynchronously and the in-flight write is lost. The free counter resets alongside.

## Timing
- Handshake in cycle t → `o_wr_en`/addr/data valid in cycle t+1, a single-cycle pulse per flit.
- Throughput is 1 flit/cycle while eff_free permits.
- `i_retry_num_free_buff` is used in the cycle it is sampled, with no extra registering.
- `i_replay_active` blocks grants in the same cycle it rises. Grants resume the cycle after it falls.

## Structure
- Package `retry_pkg` holds:
  - `FLIT_W`, `BUFF_DEPTH` and `PTR_W` constants.
  - the `wr_sched_state_e` {RUN, REPLAY} typedef.
  - the `grant_src_e` {PROT, LLC} typedef.
- One sub-module, `rr_arb2`: a 2-requester round-robin arbiter with a last-grant register and `i_en` update gating.

## Test plan
- Reset, free=64, `i_prot_valid`=1 continuously → ready every cycle. `o_wr_en` pulses at t+1 with addresses 0,1,2…; after 64 writes the address wraps to 0.
- free=2, both valid, `LLC_RESERVE`=1 → cycle 0 protocol granted. Cycle 1 sees eff_free=1, so only LLCTRL is granted. Cycle 2 with free still 1 and `o_wr_en`=1 gives eff_free=0 → no grant.
- free=64, both valid continuously → grants alternate PROT, LLC, PROT…; `o_wr_is_llc` toggles 0,1,0.
- Assert `i_replay_active` for 5 cycles with both valid → both readies are 0 for those 5 cycles and `o_wr_en`=0. The grant resumes the cycle after deassertion, without dropping the pointer.
- At wr_ptr=17, assert `i_flush` → next write uses `o_wr_addr`=0 and protocol wins the first tie.
- Assert `i_rst` while `o_wr_en`=1 → `o_wr_en` is 0 immediately, asynchronously. After release, all outputs are 0 and the first write goes to address 0.
